io_tx_packet_master: RTL and testbench

IO_TX_PACKET_MASTER -- requirements
Module: io_tx_packet_master

---
 rtl/io_pkg.sv | 41 ++++
 rtl/io_wb_write_beat.sv | 47 ++++
 rtl/io_tx_packet_master.sv | 213 +++++++++++++++++++++
 tb/tb_io_tx_packet_master.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_pkg.sv
// Shared definitions for the IO packet controllers (TX master and RX-side controller).
// Holds the controller state encoding, fixed header words and packet size limits.
package io_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StHdr,
      StFetch,
      StData,
      StDone,
      StAbort
   } io_state_e;

   localparam logic [31:0] HDR_HOST = 32'h484f_5354;
   localparam logic [31:0] HDR_PCPU = 32'h5043_5055;
   localparam logic [31:0] HDR_RISC = 32'h5249_5343;

   localparam logic [15:0] HDR_WORDS         = 16'd6;
   localparam logic [15:0] MAX_PAYLOAD_WORDS = 16'd369;

   // Header word k of a packet; the length field carries the payload byte count in 16 bits.
   function automatic logic [31:0] hdr_word(input logic [2:0]  idx,
                                            input logic [15:0] pp_type,
                                            input logic [15:0] mem_id,
                                            input logic [15:0] n,
                                            input logic [15:0] m,
                                            input logic [15:0] len);
      logic [31:0] w;
      case (idx)
         3'd0:    w = HDR_HOST;
         3'd1:    w = HDR_PCPU;
         3'd2:    w = HDR_RISC;
         3'd3:    w = {16'h0000, pp_type};
         3'd4:    w = {len[13:0], 2'b00, mem_id};
         3'd5:    w = {n, m};
         default: w = 32'h0000_0000;
      endcase
      return w;
   endfunction

endpackage

// File: rtl/io_wb_write_beat.sv
// Single-beat WISHBONE write handshake: latches address/data on request and holds the
// strobe until ack or err; the strobe is always low for at least one cycle between beats.
module io_wb_write_beat
   import io_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_req,
   input  logic [31:0] i_adr,
   input  logic [31:0] i_dat,
   input  logic        i_ack,
   input  logic        i_err,
   output logic        o_stb,
   output logic [31:0] o_adr,
   output logic [31:0] o_dat,
   output logic        o_done,
   output logic        o_err
);

   logic        r_stb;
   logic [31:0] r_adr;
   logic [31:0] r_dat;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_stb <= 1'b0;
         r_adr <= 32'h0000_0000;
         r_dat <= 32'h0000_0000;
      end else if (r_stb) begin
         if (i_ack || i_err) begin
            r_stb <= 1'b0;
         end
      end else if (i_req) begin
         r_stb <= 1'b1;
         r_adr <= i_adr;
         r_dat <= i_dat;
      end
   end

   // Responses arriving while the strobe is low are not ours and are dropped.
   assign o_err  = r_stb & i_err;
   assign o_done = r_stb & i_ack & ~i_err;
   assign o_stb  = r_stb;
   assign o_adr  = r_adr;
   assign o_dat  = r_dat;

endmodule

// File: rtl/io_tx_packet_master.sv
// TX packet master: writes a six-word header followed by payload words fetched from
// MAGIC global memory into a TX buffer over a WISHBONE master port.
module io_tx_packet_master
   import io_pkg::*;
(
   input  logic        wb_clk_i,
   input  logic        wb_rst_n_i,
   input  logic        start_i,
   input  logic [15:0] pp_type_i,
   input  logic [15:0] mem_id_i,
   input  logic [15:0] n_i,
   input  logic [15:0] M_i,
   input  logic [15:0] len_i,
   input  logic [31:0] src_ptr_i,
   input  logic [31:0] base_adr_i,
   output logic        busy_o,
   output logic        done_o,
   output logic        err_o,
   output logic [15:0] tx_len_o,
   output logic [31:0] mem_addr_o,
   output logic        mem_gl_en_o,
   input  logic [31:0] mem_gl_data_r_i,
   output logic [31:0] wb_adr_o,
   output logic [31:0] wb_dat_o,
   output logic [3:0]  wb_sel_o,
   output logic        wb_we_o,
   output logic        wb_cyc_o,
   output logic        wb_stb_o,
   input  logic        wb_ack_i,
   input  logic        wb_err_i
);

   io_state_e   r_state;
   io_state_e   w_state_next;

   logic [15:0] r_idx;
   logic [15:0] r_pp_type;
   logic [15:0] r_mem_id;
   logic [15:0] r_n;
   logic [15:0] r_m;
   logic [15:0] r_len;
   logic [31:0] r_src;
   logic [31:0] r_base;
   logic [31:0] r_hold;
   logic        r_cap;
   logic        r_len_err;
   logic [15:0] r_tx_len;

   logic        w_start_ok;
   logic        w_start_bad;
   logic        w_hdr_last;
   logic        w_pay_last;
   logic        w_beat_req;
   logic [31:0] w_beat_adr;
   logic [31:0] w_beat_dat;
   logic        w_beat_stb;
   logic        w_beat_done;
   logic        w_beat_err;
   logic [31:0] w_idx_bytes;

   assign w_start_ok  = (r_state == StIdle) && start_i && (len_i <= MAX_PAYLOAD_WORDS);
   assign w_start_bad = (r_state == StIdle) && start_i && (len_i >  MAX_PAYLOAD_WORDS);
   assign w_hdr_last  = (r_idx == HDR_WORDS - 16'd1);
   assign w_pay_last  = (r_idx == r_len - 16'd1);
   assign w_idx_bytes = {14'd0, r_idx, 2'b00};

   // State register
   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         StIdle: begin
            if (w_start_ok) begin
               w_state_next = StHdr;
            end
         end
         StHdr: begin
            if (w_beat_err) begin
               w_state_next = StAbort;
            end else if (w_beat_done && w_hdr_last) begin
               w_state_next = (r_len == 16'd0) ? StDone : StFetch;
            end
         end
         StFetch: begin
            w_state_next = StData;
         end
         StData: begin
            if (w_beat_err) begin
               w_state_next = StAbort;
            end else if (w_beat_done) begin
               w_state_next = w_pay_last ? StDone : StFetch;
            end
         end
         StDone:  w_state_next = StIdle;
         StAbort: w_state_next = StIdle;
         default: w_state_next = StIdle;
      endcase
   end

   // Packet fields, word counter and payload holding register
   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) begin
         r_idx     <= 16'd0;
         r_pp_type <= 16'd0;
         r_mem_id  <= 16'd0;
         r_n       <= 16'd0;
         r_m       <= 16'd0;
         r_len     <= 16'd0;
         r_src     <= 32'd0;
         r_base    <= 32'd0;
         r_hold    <= 32'd0;
         r_cap     <= 1'b0;
         r_len_err <= 1'b0;
         r_tx_len  <= 16'd0;
      end else begin
         r_len_err <= w_start_bad;
         if (w_start_ok) begin
            r_idx     <= 16'd0;
            r_pp_type <= pp_type_i;
            r_mem_id  <= mem_id_i;
            r_n       <= n_i;
            r_m       <= M_i;
            r_len     <= len_i;
            r_src     <= src_ptr_i;
            r_base    <= base_adr_i;
            r_tx_len  <= 16'd24 + {len_i[13:0], 2'b00};
         end
         if ((r_state == StHdr) && w_beat_done) begin
            r_idx <= w_hdr_last ? 16'd0 : r_idx + 16'd1;
         end
         if (r_state == StFetch) begin
            r_cap <= 1'b1;
         end
         if (r_state == StData) begin
            // Read data is valid exactly one cycle after the fetch strobe.
            if (r_cap) begin
               r_hold <= mem_gl_data_r_i;
               r_cap  <= 1'b0;
            end
            if (w_beat_done) begin
               r_idx <= r_idx + 16'd1;
            end
         end
      end
   end

   // Output and beat-request logic
   always_comb begin
      w_beat_req  = 1'b0;
      w_beat_adr  = 32'd0;
      w_beat_dat  = 32'd0;
      mem_gl_en_o = 1'b0;
      mem_addr_o  = 32'd0;
      busy_o      = 1'b0;
      wb_cyc_o    = 1'b0;
      done_o      = 1'b0;
      err_o       = r_len_err;
      unique case (r_state)
         StHdr: begin
            busy_o     = 1'b1;
            wb_cyc_o   = 1'b1;
            w_beat_req = 1'b1;
            w_beat_adr = r_base + w_idx_bytes;
            w_beat_dat = hdr_word(r_idx[2:0], r_pp_type, r_mem_id, r_n, r_m, r_len);
         end
         StFetch: begin
            busy_o      = 1'b1;
            wb_cyc_o    = 1'b1;
            mem_gl_en_o = 1'b1;
            mem_addr_o  = r_src + {16'd0, r_idx};
         end
         StData: begin
            busy_o     = 1'b1;
            wb_cyc_o   = 1'b1;
            w_beat_req = ~r_cap;
            w_beat_adr = r_base + 32'd24 + w_idx_bytes;
            w_beat_dat = r_hold;
         end
         StDone:  done_o = 1'b1;
         StAbort: err_o  = 1'b1;
         default: ;
      endcase
   end

   assign wb_we_o  = wb_cyc_o;
   assign wb_sel_o = wb_cyc_o ? 4'hF : 4'h0;
   assign wb_stb_o = w_beat_stb & wb_cyc_o;
   assign tx_len_o = r_tx_len;

   io_wb_write_beat u_beat (
      .i_clk   (wb_clk_i),
      .i_rst_n (wb_rst_n_i),
      .i_req   (w_beat_req),
      .i_adr   (w_beat_adr),
      .i_dat   (w_beat_dat),
      .i_ack   (wb_ack_i),
      .i_err   (wb_err_i),
      .o_stb   (w_beat_stb),
      .o_adr   (wb_adr_o),
      .o_dat   (wb_dat_o),
      .o_done  (w_beat_done),
      .o_err   (w_beat_err)
   );

endmodule

// File: tb/tb_io_tx_packet_master.sv
// Scoreboard bench for io_tx_packet_master: directed packets push expected bus writes and
// memory reads into queues; a monitor pops and compares as the DUT presents them.
module tb_io_tx_packet_master;

   typedef struct packed {
      logic [31:0] adr;
      logic [31:0] dat;
   } wr_t;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [15:0] pp_type, mem_id, n_f, m_f, len;
   logic [31:0] src_ptr, base_adr;
   logic        busy, done, err;
   logic [15:0] tx_len;
   logic [31:0] mem_addr;
   logic        mem_en;
   logic [31:0] mem_data;
   logic [31:0] wb_adr, wb_dat;
   logic [3:0]  wb_sel;
   logic        wb_we, wb_cyc, wb_stb;
   logic        ack, werr;

   wr_t         wr_q[$];
   logic [31:0] mem_q[$];

   int n_chk = 0;
   int n_err = 0;
   int done_cnt = 0, err_cnt = 0, cyc_cnt = 0, mem_cnt = 0, stb_cnt_all = 0;
   int beat_no = 0, delay_beat = -1, delay_n = 0, err_beat = -1;
   int stb_run = 0;
   logic gap_chk = 1'b0, err_chk = 1'b0;
   logic        en_s = 1'b0;
   logic [31:0] adr_s = 32'd0;

   io_tx_packet_master dut (
      .wb_clk_i        (clk),
      .wb_rst_n_i      (rst_n),
      .start_i         (start),
      .pp_type_i       (pp_type),
      .mem_id_i        (mem_id),
      .n_i             (n_f),
      .M_i             (m_f),
      .len_i           (len),
      .src_ptr_i       (src_ptr),
      .base_adr_i      (base_adr),
      .busy_o          (busy),
      .done_o          (done),
      .err_o           (err),
      .tx_len_o        (tx_len),
      .mem_addr_o      (mem_addr),
      .mem_gl_en_o     (mem_en),
      .mem_gl_data_r_i (mem_data),
      .wb_adr_o        (wb_adr),
      .wb_dat_o        (wb_dat),
      .wb_sel_o        (wb_sel),
      .wb_we_o         (wb_we),
      .wb_cyc_o        (wb_cyc),
      .wb_stb_o        (wb_stb),
      .wb_ack_i        (ack),
      .wb_err_i        (werr)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic push_wr(input logic [31:0] a, input logic [31:0] d);
      wr_t e;
      e.adr = a;
      e.dat = d;
      wr_q.push_back(e);
   endtask

   task automatic push_magic(input logic [31:0] b);
      push_wr(b,         32'h484f5354);
      push_wr(b + 32'd4, 32'h50435055);
      push_wr(b + 32'd8, 32'h52495343);
   endtask

   task automatic start_pkt(input logic [15:0] p, input logic [15:0] mi, input logic [15:0] nn,
                            input logic [15:0] mm, input logic [15:0] l,
                            input logic [31:0] s, input logic [31:0] b);
      @(negedge clk);
      pp_type = p; mem_id = mi; n_f = nn; m_f = mm; len = l; src_ptr = s; base_adr = b;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_end(input string name);
      int   s;
      logic seen;
      s    = done_cnt + err_cnt;
      seen = 1'b0;
      for (int i = 0; i < 300 && !seen; i++) begin
         @(posedge clk);
         if (done_cnt + err_cnt != s) seen = 1'b1;
      end
      if (!seen) begin
         n_chk++;
         n_err++;
         $display("FAIL %s: timeout waiting for done/err, got none expected a pulse", name);
      end
      repeat (3) @(negedge clk);
   endtask

   // WISHBONE slave: ack (or err) each beat after a per-beat number of wait cycles.
   initial begin
      ack  = 1'b0;
      werr = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         ack  = 1'b0;
         werr = 1'b0;
         if (wb_stb) begin
            if (stb_run == ((beat_no == delay_beat) ? delay_n : 0)) begin
               if (beat_no == err_beat) werr = 1'b1;
               else                     ack  = 1'b1;
               beat_no++;
            end
            stb_run++;
         end else begin
            stb_run = 0;
         end
      end
   end

   // MAGIC memory: data for a fetched address appears the cycle after the enable.
   initial begin
      mem_data = 32'hDEADBEEF;
      forever begin
         @(posedge clk);
         #1;
         mem_data = en_s ? (32'hA5A50000 | {16'h0000, adr_s[15:0]}) : 32'hDEADBEEF;
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         en_s  = mem_en;
         adr_s = mem_addr;
      end
   end

   // Monitor / scoreboard
   initial begin
      wr_t         e;
      logic [31:0] ma;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (done)   done_cnt++;
            if (err)    err_cnt++;
            if (wb_cyc) cyc_cnt++;
            if (gap_chk) begin
               chk("stb_gap_after_ack", 32'(wb_stb), 32'd0);
               gap_chk = 1'b0;
            end
            if (err_chk) begin
               chk("cyc_after_err", 32'(wb_cyc), 32'd0);
               err_chk = 1'b0;
            end
            if (wb_stb) begin
               stb_cnt_all++;
               if (wr_q.size() == 0) begin
                  n_chk++;
                  n_err++;
                  $display("FAIL unexpected_beat: got adr %h dat %h expected no beat", wb_adr, wb_dat);
               end else begin
                  e = wr_q[0];
                  chk("wb_adr", wb_adr, e.adr);
                  chk("wb_dat", wb_dat, e.dat);
                  if (ack || werr) begin
                     void'(wr_q.pop_front());
                     if (ack)  gap_chk = 1'b1;
                     if (werr) err_chk = 1'b1;
                  end
               end
            end
            if (mem_en) begin
               mem_cnt++;
               if (mem_q.size() == 0) begin
                  n_chk++;
                  n_err++;
                  $display("FAIL unexpected_fetch: got addr %h expected no fetch", mem_addr);
               end else begin
                  ma = mem_q.pop_front();
                  chk("mem_addr", mem_addr, ma);
               end
            end
         end
      end
   end

   initial begin
      int d0, e0, c0, m0, s0;
      rst_n = 1'b0; start = 1'b0;
      pp_type = '0; mem_id = '0; n_f = '0; m_f = '0; len = '0; src_ptr = '0; base_adr = '0;
      repeat (2) @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_cyc", 32'(wb_cyc), 32'd0);
      chk("rst_sel", 32'(wb_sel), 32'd0);
      chk("rst_adr", wb_adr, 32'd0);
      chk("rst_tx_len", 32'(tx_len), 32'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Basic packet, plus a start pulse while busy that must be ignored.
      d0 = done_cnt; e0 = err_cnt;
      push_magic(32'h0);
      push_wr(32'h0C, 32'h00000011);
      push_wr(32'h10, 32'h00080400);
      push_wr(32'h14, 32'h00030005);
      push_wr(32'h18, 32'hA5A50100);
      push_wr(32'h1C, 32'hA5A50101);
      mem_q.push_back(32'h100); mem_q.push_back(32'h101);
      beat_no = 0;
      start_pkt(16'h0011, 16'h0400, 16'd3, 16'd5, 16'd2, 32'h100, 32'h0);
      chk("busy_in_hdr", 32'(busy), 32'd1);
      chk("sel_in_hdr", 32'(wb_sel), 32'hF);
      repeat (3) @(negedge clk);
      start_pkt(16'h7777, 16'h8888, 16'd9, 16'd9, 16'd7, 32'h900, 32'h9000);
      wait_end("t1");
      chk("t1_done", 32'(done_cnt - d0), 32'd1);
      chk("t1_err", 32'(err_cnt - e0), 32'd0);
      chk("t1_tx_len", 32'(tx_len), 32'd32);
      chk("t1_wr_left", 32'(wr_q.size()), 32'd0);
      chk("t1_mem_left", 32'(mem_q.size()), 32'd0);
      chk("t1_busy", 32'(busy), 32'd0);

      // Header-only packet.
      d0 = done_cnt; m0 = mem_cnt;
      push_magic(32'h1000);
      push_wr(32'h100C, 32'h00000033);
      push_wr(32'h1010, 32'h0000BEEF);
      push_wr(32'h1014, 32'h00010002);
      beat_no = 0;
      start_pkt(16'h0033, 16'hBEEF, 16'd1, 16'd2, 16'd0, 32'h700, 32'h1000);
      wait_end("t2");
      chk("t2_done", 32'(done_cnt - d0), 32'd1);
      chk("t2_no_fetch", 32'(mem_cnt - m0), 32'd0);
      chk("t2_tx_len", 32'(tx_len), 32'd24);
      chk("t2_wr_left", 32'(wr_q.size()), 32'd0);

      // Ack held off three cycles on header word 2.
      d0 = done_cnt; s0 = stb_cnt_all;
      push_magic(32'h2000);
      push_wr(32'h200C, 32'h00000022);
      push_wr(32'h2010, 32'h00040001);
      push_wr(32'h2014, 32'h00100020);
      push_wr(32'h2018, 32'hA5A50200);
      mem_q.push_back(32'h200);
      beat_no = 0; delay_beat = 2; delay_n = 3;
      start_pkt(16'h0022, 16'h0001, 16'h0010, 16'h0020, 16'd1, 32'h200, 32'h2000);
      wait_end("t3");
      delay_beat = -1;
      chk("t3_done", 32'(done_cnt - d0), 32'd1);
      chk("t3_stb_cycles", 32'(stb_cnt_all - s0), 32'd10);
      chk("t3_tx_len", 32'(tx_len), 32'd28);
      chk("t3_wr_left", 32'(wr_q.size()), 32'd0);

      // Bus error on payload word 0.
      d0 = done_cnt; e0 = err_cnt;
      push_magic(32'h3000);
      push_wr(32'h300C, 32'h00000066);
      push_wr(32'h3010, 32'h00080009);
      push_wr(32'h3014, 32'h00040008);
      push_wr(32'h3018, 32'hA5A50300);
      mem_q.push_back(32'h300);
      beat_no = 0; err_beat = 6;
      start_pkt(16'h0066, 16'h0009, 16'd4, 16'd8, 16'd2, 32'h300, 32'h3000);
      wait_end("t4");
      err_beat = -1;
      chk("t4_err", 32'(err_cnt - e0), 32'd1);
      chk("t4_done", 32'(done_cnt - d0), 32'd0);
      chk("t4_busy", 32'(busy), 32'd0);
      chk("t4_wr_left", 32'(wr_q.size()), 32'd0);
      chk("t4_mem_left", 32'(mem_q.size()), 32'd0);

      // New start after the abort.
      d0 = done_cnt;
      push_magic(32'h4000);
      push_wr(32'h400C, 32'h00000044);
      push_wr(32'h4010, 32'h00000007);
      push_wr(32'h4014, 32'h0009000A);
      beat_no = 0;
      start_pkt(16'h0044, 16'h0007, 16'd9, 16'hA, 16'd0, 32'h0, 32'h4000);
      wait_end("t5");
      chk("t5_done", 32'(done_cnt - d0), 32'd1);
      chk("t5_wr_left", 32'(wr_q.size()), 32'd0);

      // Oversized length.
      d0 = done_cnt; e0 = err_cnt; c0 = cyc_cnt; m0 = mem_cnt;
      start_pkt(16'h0001, 16'h0001, 16'd1, 16'd1, 16'd370, 32'h800, 32'h8000);
      chk("t6_err_pulse", 32'(err), 32'd1);
      @(negedge clk);
      chk("t6_err_one_cycle", 32'(err), 32'd0);
      repeat (4) @(negedge clk);
      chk("t6_err", 32'(err_cnt - e0), 32'd1);
      chk("t6_done", 32'(done_cnt - d0), 32'd0);
      chk("t6_no_cyc", 32'(cyc_cnt - c0), 32'd0);
      chk("t6_no_fetch", 32'(mem_cnt - m0), 32'd0);

      // Reset while in DATA.
      push_magic(32'h5000);
      push_wr(32'h500C, 32'h00000001);
      push_wr(32'h5010, 32'h000C0002);
      push_wr(32'h5014, 32'h00030004);
      push_wr(32'h5018, 32'hA5A50500);
      mem_q.push_back(32'h500);
      beat_no = 0;
      start_pkt(16'h0001, 16'h0002, 16'd3, 16'd4, 16'd3, 32'h500, 32'h5000);
      for (int i = 0; i < 100 && !mem_en; i++) @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("t7_cyc", 32'(wb_cyc), 32'd0);
      chk("t7_stb", 32'(wb_stb), 32'd0);
      chk("t7_adr", wb_adr, 32'd0);
      chk("t7_dat", wb_dat, 32'd0);
      chk("t7_tx_len", 32'(tx_len), 32'd0);
      chk("t7_busy", 32'(busy), 32'd0);
      chk("t7_we", 32'(wb_we), 32'd0);
      wr_q.delete();
      mem_q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      d0 = done_cnt; e0 = err_cnt;
      repeat (6) @(negedge clk);
      chk("t7_no_done", 32'(done_cnt - d0), 32'd0);
      chk("t7_no_err", 32'(err_cnt - e0), 32'd0);

      // Full packet after reset.
      d0 = done_cnt;
      push_magic(32'h6000);
      push_wr(32'h600C, 32'h00000055);
      push_wr(32'h6010, 32'h00041234);
      push_wr(32'h6014, 32'h01010202);
      push_wr(32'h6018, 32'hA5A50600);
      mem_q.push_back(32'h600);
      beat_no = 0;
      start_pkt(16'h0055, 16'h1234, 16'h0101, 16'h0202, 16'd1, 32'h600, 32'h6000);
      wait_end("t8");
      chk("t8_done", 32'(done_cnt - d0), 32'd1);
      chk("t8_tx_len", 32'(tx_len), 32'd28);
      chk("t8_wr_left", 32'(wr_q.size()), 32'd0);
      chk("t8_mem_left", 32'(mem_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
